// File: rtl/alu_exec_unit.sv
// ALU execute unit: ALUOp/funct7/funct3 decode with a registered result stage
// and an optional iterative multiply/divide datapath (shift-add / restoring).
//
// state | meaning
// IDLE  | no iterative op running; pending single-cycle ops complete here
// ITER  | one multiply/divide step per cycle, XLEN cycles
// FIX   | sign correction and result select for the iterative op
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [1:0]      alu_op_i,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            branch_taken_o,
    output logic            illegal_o,
    output logic            busy_o,
    output logic            done_o
);
    localparam int SH = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t            state_q;
    logic [SH-1:0]     cnt_q;
    logic              pend_q;
    logic [1:0]        op_q;
    logic [6:0]        f7_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   a_q, b_q, dvs_q;
    logic [2*XLEN-1:0] acc_q;
    logic              neg_q;
    logic [XLEN-1:0]   result_q;
    logic              zero_q, br_q, ill_q, busy_q, done_q;

    logic [SH-1:0]     shamt;
    logic [XLEN-1:0]   base_res, alu_res, res_final;
    logic              ill, br, is_m, accept;

    // Decode of the captured op into a single-cycle result or an iterative request
    always_comb begin
        shamt    = b_q[SH-1:0];
        alu_res  = '0;
        ill      = 1'b0;
        br       = 1'b0;
        is_m     = 1'b0;
        base_res = '0;
        case (f3_q)
            3'b000: base_res = a_q + b_q;
            3'b001: base_res = a_q << shamt;
            3'b010: base_res = XLEN'($signed(a_q) < $signed(b_q));
            3'b011: base_res = XLEN'(a_q < b_q);
            3'b100: base_res = a_q ^ b_q;
            3'b101: base_res = a_q >> shamt;
            3'b110: base_res = a_q | b_q;
            default: base_res = a_q & b_q;
        endcase
        case (op_q)
            2'b00: alu_res = a_q + b_q;
            2'b01: begin
                alu_res = a_q - b_q;
                case (f3_q)
                    3'b000: br = (a_q == b_q);
                    3'b001: br = (a_q != b_q);
                    3'b100: br = ($signed(a_q) < $signed(b_q));
                    3'b101: br = ($signed(a_q) >= $signed(b_q));
                    3'b110: br = (a_q < b_q);
                    3'b111: br = (a_q >= b_q);
                    default: ill = 1'b1;
                endcase
            end
            2'b10: begin
                if (f7_q == 7'b0000000) begin
                    alu_res = base_res;
                end else if (f7_q == 7'b0100000) begin
                    if (f3_q == 3'b000)      alu_res = a_q - b_q;
                    else if (f3_q == 3'b101) alu_res = $unsigned($signed(a_q) >>> shamt);
                    else                     ill = 1'b1;
                end else if (EN_M && f7_q == 7'b0000001) begin
                    is_m = 1'b1;
                end else begin
                    ill = 1'b1;
                end
            end
            default: begin
                alu_res = base_res;
                if (f3_q == 3'b001 && f7_q != 7'b0000000) ill = 1'b1;
                if (f3_q == 3'b101) begin
                    if (f7_q == 7'b0100000)      alu_res = $unsigned($signed(a_q) >>> shamt);
                    else if (f7_q != 7'b0000000) ill = 1'b1;
                end
            end
        endcase
        if (ill) br = 1'b0;
        res_final = ill ? '0 : alu_res;
    end

    logic              sa, sb, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_part, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    // Operand magnitudes, one iteration step, and the final sign fix-up
    always_comb begin
        sa       = (f3_q == 3'b001) || (f3_q == 3'b010) || (f3_q == 3'b100) || (f3_q == 3'b110);
        sb       = (f3_q == 3'b001) || (f3_q == 3'b100) || (f3_q == 3'b110);
        a_neg    = sa && a_q[XLEN-1];
        b_neg    = sb && b_q[XLEN-1];
        a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
        b_mag    = b_neg ? (~b_q + 1'b1) : b_q;
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_part = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_part - {1'b0, dvs_q};
        div_next = div_diff[XLEN] ? {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        prod     = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo      = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem      = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        if (!f3_q[2])     fix_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (f3_q[1]) fix_res = rem;
        else              fix_res = quo;
    end

    // A pending iterative op must leave IDLE before another request is taken
    assign accept = start_i && !busy_q && !(pend_q && is_m);

    // Capture, FSM and registered outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            op_q     <= '0;
            f7_q     <= '0;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dvs_q    <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            br_q     <= 1'b0;
            ill_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            pend_q <= accept;
            if (accept) begin
                op_q <= alu_op_i;
                f7_q <= funct7_i;
                f3_q <= funct3_i;
                a_q  <= operand_a_i;
                b_q  <= operand_b_i;
            end
            case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        if (is_m) begin
                            state_q <= ITER;
                            busy_q  <= 1'b1;
                            cnt_q   <= SH'(XLEN-1);
                            if (f3_q[2]) begin
                                acc_q <= {{XLEN{1'b0}}, a_mag};
                                dvs_q <= b_mag;
                                neg_q <= f3_q[1] ? a_neg : ((a_neg ^ b_neg) && (b_q != '0));
                            end else begin
                                acc_q <= {{XLEN{1'b0}}, b_mag};
                                dvs_q <= a_mag;
                                neg_q <= a_neg ^ b_neg;
                            end
                        end else begin
                            result_q <= res_final;
                            zero_q   <= (res_final == '0);
                            br_q     <= br;
                            ill_q    <= ill;
                            done_q   <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    acc_q <= f3_q[2] ? div_next : mul_next;
                    if (cnt_q == '0) state_q <= FIX;
                    else             cnt_q <= cnt_q - 1'b1;
                end
                FIX: begin
                    result_q <= fix_res;
                    zero_q   <= (fix_res == '0);
                    br_q     <= 1'b0;
                    ill_q    <= 1'b0;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result_o       = result_q;
    assign zero_o         = zero_q;
    assign branch_taken_o = br_q;
    assign illegal_o      = ill_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops push expected responses,
// a negedge monitor pops one entry per done pulse.
module tb_alu_exec_unit;
    localparam int XLEN = 32;
    localparam int LM   = XLEN + 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [1:0]      alu_op;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] opa, opb;
    logic [XLEN-1:0] res, res2;
    logic            zero, zero2, brt, brt2, ill, ill2, busy, busy2, done, done2;

    alu_exec_unit #(.XLEN(XLEN), .EN_M(1'b1)) dut (
        .clk_i(clk), .reset_i(rst), .start_i(start), .alu_op_i(alu_op),
        .funct7_i(funct7), .funct3_i(funct3), .operand_a_i(opa), .operand_b_i(opb),
        .result_o(res), .zero_o(zero), .branch_taken_o(brt), .illegal_o(ill),
        .busy_o(busy), .done_o(done));

    alu_exec_unit #(.XLEN(XLEN), .EN_M(1'b0)) dut_nom (
        .clk_i(clk), .reset_i(rst), .start_i(start), .alu_op_i(alu_op),
        .funct7_i(funct7), .funct3_i(funct3), .operand_a_i(opa), .operand_b_i(opb),
        .result_o(res2), .zero_o(zero2), .branch_taken_o(brt2), .illegal_o(ill2),
        .busy_o(busy2), .done_o(done2));

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] r;
        logic            br;
        logic            il;
        int              lat;
        int              cyc;
        string           name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.name, "_result"}, res, mon_e.r);
                chk({mon_e.name, "_zero"}, XLEN'(zero), XLEN'(mon_e.r == '0));
                chk({mon_e.name, "_branch"}, XLEN'(brt), XLEN'(mon_e.br));
                chk({mon_e.name, "_illegal"}, XLEN'(ill), XLEN'(mon_e.il));
                chk({mon_e.name, "_latency"}, XLEN'(cyc - mon_e.cyc - 1), XLEN'(mon_e.lat));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] r, input logic br, input logic il,
                         input int lat, input string nm, input bit push);
        alu_op = op; funct7 = f7; funct3 = f3; opa = a; opb = b; start = 1'b1;
        if (push) sbq.push_back('{r: r, br: br, il: il, lat: lat, cyc: cyc, name: nm});
        @(negedge clk);
        start = 1'b0;
        opa = 32'hDEAD_BEEF; opb = 32'h1234_5678; funct3 = ~f3; funct7 = ~f7;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d ops outstanding expected 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] r, input logic br, input logic il,
                       input int lat, input string nm);
        issue(op, f7, f3, a, b, r, br, il, lat, nm, 1'b1);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; alu_op = '0; funct7 = '0; funct3 = '0; opa = '0; opb = '0;
        repeat (2) @(negedge clk);
        chk("rst_result", res, '0);
        chk("rst_zero", XLEN'(zero), '0);
        chk("rst_branch", XLEN'(brt), '0);
        chk("rst_illegal", XLEN'(ill), '0);
        chk("rst_busy", XLEN'(busy), '0);
        chk("rst_done", XLEN'(done), '0);
        rst = 1'b0;
        @(negedge clk);

        run(2'b00, 7'h00, 3'b000, 32'd5, 32'd7, 32'd12, 0, 0, 1, "add");
        run(2'b10, 7'h20, 3'b000, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0, 1, "sub");
        run(2'b10, 7'h20, 3'b000, 32'd9, 32'd9, 32'h0, 0, 0, 1, "sub_zero");
        run(2'b01, 7'h00, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1, 0, 1, "blt");
        run(2'b01, 7'h00, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 0, 0, 1, "bltu");
        run(2'b01, 7'h00, 3'b001, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1, 0, 1, "bne");
        run(2'b01, 7'h00, 3'b000, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 0, 0, 1, "beq");
        run(2'b01, 7'h00, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 0, 0, 1, "bge");
        run(2'b01, 7'h00, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1, 0, 1, "bgeu");
        run(2'b01, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'h0, 0, 1, 1, "br_ill");
        run(2'b10, 7'h00, 3'b001, 32'd1, 32'h24, 32'h10, 0, 0, 1, "sll");
        run(2'b10, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 1, "slt");
        run(2'b10, 7'h00, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 1, "sltu");
        run(2'b10, 7'h00, 3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 0, 0, 1, "xor");
        run(2'b10, 7'h00, 3'b110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 0, 0, 1, "or");
        run(2'b10, 7'h00, 3'b111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0, 0, 1, "and");
        run(2'b10, 7'h00, 3'b101, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 0, 1, "srl");
        run(2'b10, 7'h20, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0, 1, "sra");
        run(2'b10, 7'h20, 3'b001, 32'd1, 32'd1, 32'h0, 0, 1, 1, "r_f7_ill");
        run(2'b10, 7'h02, 3'b000, 32'd1, 32'd1, 32'h0, 0, 1, 1, "r_f7_other");
        run(2'b11, 7'h7F, 3'b000, 32'd5, 32'd7, 32'd12, 0, 0, 1, "addi");
        run(2'b11, 7'h7F, 3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 0, 0, 1, "xori");
        run(2'b11, 7'h20, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0, 1, "srai");
        run(2'b11, 7'h20, 3'b001, 32'd1, 32'd4, 32'h0, 0, 1, 1, "slli_ill");
        run(2'b11, 7'h01, 3'b101, 32'd1, 32'd4, 32'h0, 0, 1, 1, "srli_ill");

        run(2'b10, 7'h01, 3'b001, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 0, 0, LM, "mulh");
        run(2'b10, 7'h01, 3'b011, 32'h8000_0000, 32'd2, 32'h0000_0001, 0, 0, LM, "mulhu");
        run(2'b10, 7'h01, 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, 0, LM, "mulhsu");
        run(2'b10, 7'h01, 3'b000, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 0, 0, LM, "mul");
        run(2'b10, 7'h01, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, LM, "div_ovf");
        run(2'b10, 7'h01, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0, LM, "rem_ovf");
        run(2'b10, 7'h01, 3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, 0, 0, LM, "divu_z");
        run(2'b10, 7'h01, 3'b111, 32'd7, 32'd0, 32'd7, 0, 0, LM, "remu_z");
        run(2'b10, 7'h01, 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0, 0, LM, "div_z");
        run(2'b10, 7'h01, 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0, 0, LM, "rem_z");
        run(2'b10, 7'h01, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0, LM, "div_neg");
        run(2'b10, 7'h01, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0, LM, "rem_neg");
        run(2'b10, 7'h01, 3'b101, 32'd100, 32'd7, 32'd14, 0, 0, LM, "divu");
        run(2'b10, 7'h01, 3'b111, 32'd100, 32'd7, 32'd2, 0, 0, LM, "remu");

        // Reset in the middle of a multiply aborts it without a done pulse
        issue(2'b10, 7'h01, 3'b000, 32'd3, 32'd5, '0, 0, 0, 0, "mul_abort", 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", XLEN'(busy), '0);
        chk("abort_done", XLEN'(done), '0);
        chk("abort_result", res, '0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (45) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", XLEN'(seen), '0);
        run(2'b00, 7'h00, 3'b000, 32'd20, 32'd22, 32'd42, 0, 0, 1, "add_after_rst");

        // Starts while busy are ignored; a start in the done cycle is accepted
        issue(2'b10, 7'h01, 3'b011, 32'h8000_0000, 32'd2, 32'h1, 0, 0, LM, "mulhu_busy", 1'b1);
        @(negedge clk);
        chk("busy_high", XLEN'(busy), 32'd1);
        issue(2'b00, 7'h00, 3'b000, 32'd1, 32'd1, '0, 0, 0, 0, "ign1", 1'b0);
        repeat (10) @(negedge clk);
        issue(2'b00, 7'h00, 3'b000, 32'd2, 32'd2, '0, 0, 0, 0, "ign2", 1'b0);
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_seen", XLEN'(seen), 32'd1);
        chk("done_busy_low", XLEN'(busy), '0);
        issue(2'b00, 7'h00, 3'b000, 32'd30, 32'd3, 32'd33, 0, 0, 1, "b2b_add", 1'b1);
        drain();

        // Same multiply encoding on a build without the M datapath
        issue(2'b10, 7'h01, 3'b000, 32'd3, 32'd4, 32'd12, 0, 0, LM, "mul_3x4", 1'b1);
        @(negedge clk);
        chk("nom_done", XLEN'(done2), 32'd1);
        chk("nom_illegal", XLEN'(ill2), 32'd1);
        chk("nom_result", res2, '0);
        chk("nom_zero", XLEN'(zero2), 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU-control decode in the multicycle RISC-V core.
- Merges ALUOp/funct7/funct3 decode with a registered execute stage.
- Single-cycle RV32I ops complete in one cycle; optional iterative M-extension multiply/divide.
- Sits in the EX state of the multicycle control FSM, which waits on done.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, at least 8.
- EN_M, 1, 1 enables MUL/DIV/REM decode and the iterative datapath; 0 makes funct7=0000001 illegal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only when busy=0
- alu_op  in  2  00 add, 01 branch, 10 R-type, 11 I-type ALU
- funct7  in  7  instruction bits 31:25
- funct3  in  3  instruction bits 14:12
- operand_a  in  XLEN  rs1 value
- operand_b  in  XLEN  rs2 value or immediate
- result  out  XLEN  registered result; held until the next accepted start
- zero  out  1  registered, result==0
- branch_taken  out  1  registered branch outcome; 0 when alu_op!=01
- illegal  out  1  registered; unsupported encoding for the completed op
- busy  out  1  iterative op in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: asynchronous, active-high. All outputs are 0, the FSM goes to IDLE, and the iteration counter clears. Reset aborts any in-flight op and produces no done pulse.
- Start acceptance: start is accepted only when busy=0. start while busy=1 is ignored. The cycle in which done=1 has busy=0, so a back-to-back start is allowed in that cycle.
- Operands and function fields are captured on the accepting edge. Later input changes do not affect the op.
- Decode, alu_op 00: ADD. Never illegal.
- Decode, alu_op 01: result = a-b, with branch_taken as follows.
  - funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - funct3 010/011 are illegal.
- Decode, alu_op 10, funct7 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- Decode, alu_op 10, funct7 0100000: 000 SUB, 101 SRA; other funct3 values are illegal.
- Decode, alu_op 10, funct7 0000001 (EN_M=1): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Any other funct7 under alu_op 10 is illegal.
- Decode, alu_op 11: same funct3 map as funct7 0000000, with funct7 ignored except for shifts:
  - 000 is always ADDI.
  - 001 requires funct7=0000000.
  - 101 takes 0000000 as SRLI and 0100000 as SRAI; any other funct7 is illegal.
- Shift amount is operand_b[clog2(XLEN)-1:0]. SLT and SLTU return 0 or 1, zero-extended.
- Illegal op: completes with single-cycle timing, result=0, zero=1, illegal=1, branch_taken=0.
- Single-cycle ops: start accepted at edge N; at edge N+1, result/zero/branch_taken/illegal update and done=1 for that cycle. busy stays 0.
- Iterative ops (M-extension) run through the FSM IDLE -> ITER -> FIX -> IDLE.
  - IDLE to ITER on an accepted start. Operands are converted to unsigned magnitudes per signedness (MULHSU: a signed, b unsigned). busy=1 from edge N+1.
  - ITER lasts XLEN cycles: shift-add for multiply (2*XLEN-bit accumulator), restoring for divide. The counter counts XLEN-1 down to 0.
  - FIX lasts one cycle and applies the sign correction and the result select: MUL takes the low half; MULH/MULHSU/MULHU take the high half.
  - Result, zero, and done=1 appear at edge N+XLEN+2. busy=0 in that cycle.
- Divide special cases, with the same latency:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give the dividend.
  - Signed overflow (most-negative / -1): DIV gives the dividend; REM gives 0.
- done is never asserted outside the cycle after a completion edge. result holds its value between ops.

Test Plan:
- Reset during ITER of MUL: assert reset at cycle 5. Required: busy=0, done=0, result=0 at once; no done pulse afterwards; a new ADD then completes normally.
- alu_op=10, funct7=0100000, funct3=000, a=5, b=7. Required: done at N+1, result=0xFFFFFFFE, zero=0, illegal=0. Same with a=b=9: result=0, zero=1.
- alu_op=01 sweep with a=0xFFFFFFFF, b=1:
  - BLT gives branch_taken=1; BLTU gives 0; BNE gives 1; BEQ gives 0.
  - funct3=010 gives illegal=1, result=0.
- MULH with a=0x80000000, b=2 (XLEN=32): busy 1 for cycles N+1..N+33, done at N+34, result=0xFFFFFFFF. MULHU with the same operands gives 0x00000001.
- Divide cases:
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM gives 0.
  - DIVU 7/0 gives 0xFFFFFFFF; REMU 7/0 gives 7.
  - DIV -7/2 gives 0xFFFFFFFD; REM gives 0xFFFFFFFF.
- start pulses during busy are ignored, with the result unchanged. A start issued in the done cycle is accepted and its single-cycle op completes at the next edge. With EN_M=0, funct7=0000001 gives illegal=1 in 1 cycle.
